// File: rtl/stream_pkt_fifo.sv
// Store-and-forward packet FIFO: beats are released downstream only once the
// packet's last beat is stored, or in cut-through mode when the buffer is full
// without a complete packet (a packet longer than DEPTH would otherwise deadlock).
module stream_pkt_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID___WIDTH = 1,
  parameter int DEPTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [T_DATA_WIDTH-1:0]      s_data_i,
  input  logic [T_ID___WIDTH-1:0]      s_id_i,
  input  logic                         s_last_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  output logic [T_DATA_WIDTH-1:0]      m_data_o,
  output logic [T_ID___WIDTH-1:0]      m_id_o,
  output logic                         m_last_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = T_DATA_WIDTH + T_ID___WIDTH + 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] pkt_cnt;
  logic          empty;
  logic          full;
  logic          wr;
  logic          rd;
  logic [EW-1:0] head;

  // Pointer MSB is the wrap flag: equal pointers mean empty, equal index with
  // opposite wrap flags means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A slot freed by a read only becomes writable after the edge (no write-through).
  assign s_ready_o = !full;
  assign wr        = s_valid_i && s_ready_o;

  // Present the head beat once a full packet is stored, or cut through when full.
  assign m_valid_o = !empty && ((pkt_cnt != '0) || full);
  assign rd        = m_valid_o && m_ready_i;

  // Show-ahead head beat; only changes when rd_ptr moves, so it holds under backpressure.
  assign head                          = mem[rd_ptr[AW-1:0]];
  assign {m_data_o, m_id_o, m_last_o}  = head;
  assign pkt_cnt_o                     = pkt_cnt;

  // Beat storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr[AW-1:0]] <= {s_data_i, s_id_i, s_last_i};
    end
  end

  // Write and read pointers; reset discards everything stored, partial packets included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Complete-packet count: a last beat in and a last beat out on one edge cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr && s_last_i, rd && m_last_o})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Bench for stream_pkt_fifo: a queue-based model of the packet buffer is compared
// against the DUT every cycle, with directed scenarios plus a random packet run.
module tb_stream_pkt_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_id = 1'b0;
  logic       s_last = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_id_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready = 1'b0;
  logic [4:0] pkt_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       id;
    logic       last;
  } beat_t;

  beat_t q[$];
  bit    mw, mr;

  stream_pkt_fifo #(.T_DATA_WIDTH(8), .T_ID___WIDTH(1), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_id_i    (s_id),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_id_o    (m_id_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready),
    .pkt_cnt_o (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: complete packets stored = number of last beats in the queue.
  function automatic int exp_cnt();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  function automatic bit exp_valid();
    return (q.size() != 0) && (exp_cnt() != 0 || q.size() == DEPTH);
  endfunction

  // Model update on each edge; async reset empties it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      mw = s_valid && (q.size() < DEPTH);
      mr = exp_valid() && m_ready;
      if (mr) void'(q.pop_front());
      if (mw) q.push_back('{s_data, s_id, s_last});
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    check("s_ready", 32'(s_ready_o), 32'(q.size() < DEPTH));
    check("m_valid", 32'(m_valid_o), 32'(exp_valid()));
    check("pkt_cnt", 32'(pkt_cnt_o), 32'(exp_cnt()));
    if (exp_valid()) begin
      check("m_data", 32'(m_data_o), 32'(q[0].d));
      check("m_id",   32'(m_id_o),   32'(q[0].id));
      check("m_last", 32'(m_last_o), 32'(q[0].last));
    end
  end

  task automatic push(input logic [7:0] d, input logic id, input logic last);
    bit acc;
    int n;
    s_data = d; s_id = id; s_last = last; s_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = s_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: beat %0h not accepted after %0d cycles", d, n);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", q.size());
    end
  endtask

  function automatic int new_len();
    if ($urandom_range(24, 0) == 0) return int'($urandom_range(20, 17));
    return int'($urandom_range(6, 1));
  endfunction

  initial begin
    int  sent, beat, len, cyc;
    bit  acc;

    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", 32'(m_valid_o), 32'd0);
    check("reset_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    check("reset_s_ready", 32'(s_ready_o), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-beat packet, downstream always ready.
    m_ready = 1'b1;
    push(8'hA1, 1'b0, 1'b0);
    check("t1_hold_a1", 32'(m_valid_o), 32'd0);
    push(8'hA2, 1'b0, 1'b0);
    check("t1_hold_a2", 32'(m_valid_o), 32'd0);
    push(8'hA3, 1'b0, 1'b1);
    check("t1_v1", 32'(m_valid_o), 32'd1);
    check("t1_d1", 32'(m_data_o), 32'hA1);
    check("t1_l1", 32'(m_last_o), 32'd0);
    @(posedge clk); #1;
    check("t1_d2", 32'(m_data_o), 32'hA2);
    check("t1_l2", 32'(m_last_o), 32'd0);
    @(posedge clk); #1;
    check("t1_d3", 32'(m_data_o), 32'hA3);
    check("t1_l3", 32'(m_last_o), 32'd1);
    @(posedge clk); #1;
    check("t1_done", 32'(m_valid_o), 32'd0);

    // Four 4-beat packets fill the buffer under backpressure.
    m_ready = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 4; b++)
        push(8'(16 * p + b), 1'(p), b == 3);
    check("t2_full_ready", 32'(s_ready_o), 32'd0);
    check("t2_pkt_cnt", 32'(pkt_cnt_o), 32'd4);
    check("t2_head", 32'(m_data_o), 32'h00);
    drain();
    check("t2_empty_cnt", 32'(pkt_cnt_o), 32'd0);
    check("t2_empty_valid", 32'(m_valid_o), 32'd0);

    // 20-beat packet: cut-through release once full.
    m_ready = 1'b0;
    for (int b = 0; b < 16; b++) push(8'(8'h40 + b), 1'b1, 1'b0);
    check("t3_full_ready", 32'(s_ready_o), 32'd0);
    check("t3_cut_valid", 32'(m_valid_o), 32'd1);
    check("t3_cnt0", 32'(pkt_cnt_o), 32'd0);
    m_ready = 1'b1;
    for (int b = 16; b < 20; b++) push(8'(8'h40 + b), 1'b1, b == 19);
    drain();

    // Last beat in and last beat out on the same edge.
    m_ready = 1'b0;
    push(8'h55, 1'b0, 1'b1);
    s_data = 8'h66; s_id = 1'b1; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    check("t4_cnt_before", 32'(pkt_cnt_o), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    check("t4_cnt_after", 32'(pkt_cnt_o), 32'd1);
    check("t4_head", 32'(m_data_o), 32'h66);
    drain();

    // Random traffic, 1000 packets.
    m_ready = 1'b0;
    sent = 0; beat = 0; len = new_len(); cyc = 0;
    while (sent < 1000 && cyc < 60000) begin
      @(negedge clk);
      acc = s_valid && s_ready_o;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (s_last) begin sent++; beat = 0; len = new_len(); end
        else beat++;
      end
      if (!s_valid || acc) begin
        if (sent < 1000 && $urandom_range(1, 0) == 1) begin
          s_valid = 1'b1;
          s_data  = 8'($urandom);
          s_id    = 1'($urandom);
          s_last  = (beat == len - 1);
        end else begin
          s_valid = 1'b0;
        end
      end
      m_ready = 1'($urandom);
    end
    checks++;
    if (sent < 1000) begin
      errors++;
      $display("FAIL random_timeout: %0d packets sent, expected 1000", sent);
    end
    s_valid = 1'b0;
    drain();

    // Async reset with one complete and one partial packet stored.
    m_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    push(8'h12, 1'b0, 1'b1);
    push(8'h13, 1'b1, 1'b0);
    push(8'h14, 1'b1, 1'b0);
    push(8'h15, 1'b1, 1'b0);
    check("t6_pre_cnt", 32'(pkt_cnt_o), 32'd1);
    check("t6_pre_valid", 32'(m_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_valid_o), 32'd0);
    check("t6_rst_cnt", 32'(pkt_cnt_o), 32'd0);
    check("t6_rst_ready", 32'(s_ready_o), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(8'h21, 1'b1, 1'b0);
    push(8'h22, 1'b1, 1'b1);
    check("t6_new_head", 32'(m_data_o), 32'h21);
    check("t6_new_cnt", 32'(pkt_cnt_o), 32'd1);
    drain();
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
